// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - four-requester round-robin arbiter onto a two-port RAM
// Optional co-issue of a second read on RAM port 1: define RAM_ARB_DUAL_ISSUE_EN.
// Default build (macro undefined): one service per cycle on port 0, port 1 tied off.
module ram_port_arbiter #(
   parameter int BIT_WIDTH  = 16,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [3:0]              req,
   input  logic [3:0]              we,
   input  logic [4*ADDR_WIDTH-1:0] addr,
   input  logic [4*BIT_WIDTH-1:0]  wdata,
   output logic [3:0]              ack,
   output logic [4*BIT_WIDTH-1:0]  rdata,
   output logic                    ram_load0,
   output logic                    ram_save,
   output logic [ADDR_WIDTH-1:0]   ram_address0,
   output logic [BIT_WIDTH-1:0]    ram_in,
   output logic                    ram_load1,
   output logic [ADDR_WIDTH-1:0]   ram_address1,
   input  logic [BIT_WIDTH-1:0]    ram_out0,
   input  logic [BIT_WIDTH-1:0]    ram_out1
);

   logic [1:0]             ptr_q, ptr_d;
   logic [3:0]             ack_q, ack_d;
   logic [4*BIT_WIDTH-1:0] rdata_q, rdata_d;

   logic [3:0] elig;
   logic       gnt0_vld;
   logic [1:0] gnt0_idx;
   logic       gnt1_vld;
   logic [1:0] gnt1_idx;

   assign ack   = ack_q;
   assign rdata = rdata_q;

   // Requesters still showing their ack this cycle are excluded so a held req
   // is not mistaken for a new transaction; reset suppresses every grant.
   always_comb begin
      elig = rst ? 4'b0000 : (req & ~ack_q);
   end

   // Port-0 round-robin pick: scan downwards so the smallest offset from ptr wins.
   always_comb begin
      gnt0_vld = 1'b0;
      gnt0_idx = ptr_q;
      for (int k = 3; k >= 0; k--) begin
         if (elig[ptr_q + 2'(k)]) begin
            gnt0_vld = 1'b1;
            gnt0_idx = ptr_q + 2'(k);
         end
      end
   end

   // Port-0 RAM controls follow the grant combinationally; idle drives zeros.
   always_comb begin
      ram_load0    = 1'b0;
      ram_save     = 1'b0;
      ram_address0 = '0;
      ram_in       = '0;
      if (gnt0_vld) begin
         ram_address0 = addr[gnt0_idx*ADDR_WIDTH +: ADDR_WIDTH];
         if (we[gnt0_idx]) begin
            ram_save = 1'b1;
            ram_in   = wdata[gnt0_idx*BIT_WIDTH +: BIT_WIDTH];
         end else begin
            ram_load0 = 1'b1;
         end
      end
   end

`ifdef RAM_ARB_DUAL_ISSUE_EN
   logic [1:0] cand1;

   // Port-1 pick: next eligible reader after the port-0 grantee, skipping a
   // reader whose address collides with a write issued on port 0 this cycle.
   always_comb begin
      gnt1_vld = 1'b0;
      gnt1_idx = 2'd0;
      cand1    = 2'd0;
      if (gnt0_vld) begin
         for (int k = 3; k >= 1; k--) begin
            cand1 = gnt0_idx + 2'(k);
            if (elig[cand1] && !we[cand1] &&
                !(ram_save && (addr[cand1*ADDR_WIDTH +: ADDR_WIDTH] == ram_address0))) begin
               gnt1_vld = 1'b1;
               gnt1_idx = cand1;
            end
         end
      end
   end

   // Port-1 read controls follow the port-1 grant combinationally.
   always_comb begin
      ram_load1    = gnt1_vld;
      ram_address1 = gnt1_vld ? addr[gnt1_idx*ADDR_WIDTH +: ADDR_WIDTH] : '0;
   end
`else
   assign gnt1_vld     = 1'b0;
   assign gnt1_idx     = 2'd0;
   assign ram_load1    = 1'b0;
   assign ram_address1 = '0;
`endif

   // Next state: pulse ack for each grantee, capture read data, advance ptr
   // past the port-0 grantee only.
   always_comb begin
      ptr_d   = ptr_q;
      ack_d   = 4'b0000;
      rdata_d = rdata_q;
      if (gnt0_vld) begin
         ptr_d           = gnt0_idx + 2'd1;
         ack_d[gnt0_idx] = 1'b1;
         if (!we[gnt0_idx]) begin
            rdata_d[gnt0_idx*BIT_WIDTH +: BIT_WIDTH] = ram_out0;
         end
      end
      if (gnt1_vld) begin
         ack_d[gnt1_idx] = 1'b1;
         rdata_d[gnt1_idx*BIT_WIDTH +: BIT_WIDTH] = ram_out1;
      end
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q   <= 2'd0;
         ack_q   <= 4'b0000;
         rdata_q <= '0;
      end else begin
         ptr_q   <= ptr_d;
         ack_q   <= ack_d;
         rdata_q <= rdata_d;
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - self-checking bench for ram_port_arbiter
module tb_ram_port_arbiter;
   localparam int BW = 16;
   localparam int AW = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic [3:0]      req, we;
   logic [4*AW-1:0] addr;
   logic [4*BW-1:0] wdata;
   logic [3:0]      ack;
   logic [4*BW-1:0] rdata;
   logic            ram_load0, ram_save, ram_load1;
   logic [AW-1:0]   ram_address0, ram_address1;
   logic [BW-1:0]   ram_in, ram_out0, ram_out1;

   ram_port_arbiter #(.BIT_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .ack(ack), .rdata(rdata),
      .ram_load0(ram_load0), .ram_save(ram_save), .ram_address0(ram_address0),
      .ram_in(ram_in), .ram_load1(ram_load1), .ram_address1(ram_address1),
      .ram_out0(ram_out0), .ram_out1(ram_out1)
   );

   always #5 clk = ~clk;

   // RAM model: combinational reads on both ports, write on port 0 at the edge.
   logic [BW-1:0] mem [0:65535];
   assign ram_out0 = mem[ram_address0];
   assign ram_out1 = mem[ram_address1];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 65536; i++) mem[i] <= '0;
      end else if (ram_save) begin
         mem[ram_address0] <= ram_in;
      end
   end

   int nvec  = 0;
   int nfail = 0;

   typedef struct {
      int            id;
      logic [BW-1:0] data;
   } sb_t;
   sb_t           sb[$];
   logic [BW-1:0] last_rd [4];

   typedef struct {
      int            id;
      logic          w;
      logic [AW-1:0] a;
      logic [BW-1:0] d;
      logic [BW-1:0] exp_rd;
   } vec_t;
   vec_t tbl [11];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_rd(input int id, input logic [BW-1:0] d);
      sb_t e;
      e.id = id;
      e.data = d;
      sb.push_back(e);
      last_rd[id] = d;
   endtask

   task automatic push_wr(input int id);
      sb_t e;
      e.id = id;
      e.data = last_rd[id];
      sb.push_back(e);
   endtask

   task automatic mon();
      sb_t e;
      for (int i = 0; i < 4; i++) begin
         if (ack[i]) begin
            if (sb.size() == 0) begin
               nvec++;
               nfail++;
               $display("FAIL unexpected_ack: got ack[%0d]=1 expected no ack at %0t", i, $time);
            end else begin
               e = sb.pop_front();
               chk("ack_id", 64'(i), 64'(e.id));
               chk("rdata", 64'(rdata[i*BW +: BW]), 64'(e.data));
            end
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      mon();
   endtask

   task automatic clear_model();
      for (int i = 0; i < 4; i++) last_rd[i] = '0;
   endtask

   task automatic apply_vec(input vec_t v);
      req = 4'(1 << v.id);
      we  = 4'(v.w << v.id);
      addr[v.id*AW +: AW]  = v.a;
      wdata[v.id*BW +: BW] = v.d;
      #1;
      chk("vec_load0", 64'(ram_load0), 64'(!v.w));
      chk("vec_save", 64'(ram_save), 64'(v.w));
      chk("vec_addr0", 64'(ram_address0), 64'(v.a));
      if (v.w) chk("vec_ram_in", 64'(ram_in), 64'(v.d));
      chk("vec_load1", 64'(ram_load1), 64'd0);
      if (v.w) push_wr(v.id);
      else     push_rd(v.id, v.exp_rd);
      cycle();
      chk("vec_ack", 64'(ack), 64'(1 << v.id));
      req = 4'b0000;
      we  = 4'b0000;
      cycle();
   endtask

   initial begin
      tbl[0]  = '{1, 1'b1, 16'h0020, 16'h1234, 16'h0000};
      tbl[1]  = '{3, 1'b1, 16'h0030, 16'hA5A5, 16'h0000};
      tbl[2]  = '{2, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
      tbl[3]  = '{0, 1'b0, 16'h0020, 16'h0000, 16'h1234};
      tbl[4]  = '{1, 1'b0, 16'h0030, 16'h0000, 16'hA5A5};
      tbl[5]  = '{0, 1'b1, 16'h0001, 16'h1111, 16'h0000};
      tbl[6]  = '{2, 1'b1, 16'h0002, 16'h2222, 16'h0000};
      tbl[7]  = '{1, 1'b1, 16'h0030, 16'h0000, 16'h0000};
      tbl[8]  = '{1, 1'b0, 16'h0030, 16'h0000, 16'h0000};
      tbl[9]  = '{2, 1'b1, 16'hFFFF, 16'h7E7E, 16'h0000};
      tbl[10] = '{3, 1'b0, 16'hFFFF, 16'h0000, 16'h7E7E};

      clear_model();
      rst = 1'b1; req = 4'b1010; we = 4'b0000; addr = '0; wdata = '0;
      addr[1*AW +: AW] = 16'h0004;
      addr[3*AW +: AW] = 16'h0008;

      // Reset with requests pending: nothing issued, nothing acked.
      for (int c = 0; c < 2; c++) begin
         cycle();
         chk("rst_load0", 64'(ram_load0), 64'd0);
         chk("rst_save", 64'(ram_save), 64'd0);
         chk("rst_addr0", 64'(ram_address0), 64'd0);
         chk("rst_load1", 64'(ram_load1), 64'd0);
         chk("rst_ack", 64'(ack), 64'd0);
         chk("rst_ptr", 64'(dut.ptr_q), 64'd0);
         chk("rst_rdata", 64'(rdata), 64'd0);
      end
      rst = 1'b0;
      #1;
      chk("rel_load0", 64'(ram_load0), 64'd1);
      chk("rel_addr0", 64'(ram_address0), 64'h0004);
`ifdef RAM_ARB_DUAL_ISSUE_EN
      chk("rel_load1", 64'(ram_load1), 64'd1);
      chk("rel_addr1", 64'(ram_address1), 64'h0008);
      push_rd(1, 16'h0000);
      push_rd(3, 16'h0000);
      cycle();
      chk("rel_ack", 64'(ack), 64'b1010);
      req = 4'b0000;
`else
      chk("rel_load1", 64'(ram_load1), 64'd0);
      push_rd(1, 16'h0000);
      cycle();
      chk("rel_ack1", 64'(ack), 64'b0010);
      req = 4'b1000;
      #1;
      chk("rel_addr0_3", 64'(ram_address0), 64'h0008);
      push_rd(3, 16'h0000);
      cycle();
      chk("rel_ack3", 64'(ack), 64'b1000);
      req = 4'b0000;
`endif
      cycle();

      // Fresh reset, then a single write from requester 0.
      rst = 1'b1;
      cycle();
      cycle();
      clear_model();
      chk("rst2_ptr", 64'(dut.ptr_q), 64'd0);
      rst = 1'b0;
      req = 4'b0001; we = 4'b0001;
      addr[0*AW +: AW]  = 16'h0010;
      wdata[0*BW +: BW] = 16'hBEEF;
      #1;
      chk("w0_save", 64'(ram_save), 64'd1);
      chk("w0_load0", 64'(ram_load0), 64'd0);
      chk("w0_addr0", 64'(ram_address0), 64'h0010);
      chk("w0_ram_in", 64'(ram_in), 64'hBEEF);
      push_wr(0);
      cycle();
      chk("w0_ack", 64'(ack), 64'b0001);
      chk("w0_ptr", 64'(dut.ptr_q), 64'd1);
      req = 4'b0000; we = 4'b0000;
      cycle();

      for (int i = 0; i < 11; i++) apply_vec(tbl[i]);

      // All four writing continuously: service rotates 0,1,2,3,0.
      req = 4'b1111; we = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         addr[i*AW +: AW]  = 16'(16'h0040 + i);
         wdata[i*BW +: BW] = 16'(16'hC000 + i);
      end
      for (int k = 0; k < 5; k++) push_wr(k % 4);
      #1;
      chk("rr_first_addr", 64'(ram_address0), 64'h0040);
      for (int k = 0; k < 5; k++) begin
         cycle();
         chk("rr_ack", 64'(ack), 64'(1 << (k % 4)));
      end
      req = 4'b0000; we = 4'b0000;
      cycle();
      chk("rr_idle_ack", 64'(ack), 64'd0);
      chk("rr_ptr", 64'(dut.ptr_q), 64'd1);

      // Two readers at once.
      req = 4'b0011; we = 4'b0000;
      addr[0*AW +: AW] = 16'h0001;
      addr[1*AW +: AW] = 16'h0002;
      #1;
      chk("dual_load0", 64'(ram_load0), 64'd1);
      chk("dual_addr0", 64'(ram_address0), 64'h0002);
`ifdef RAM_ARB_DUAL_ISSUE_EN
      chk("dual_load1", 64'(ram_load1), 64'd1);
      chk("dual_addr1", 64'(ram_address1), 64'h0001);
      push_rd(0, 16'h1111);
      push_rd(1, 16'h2222);
      cycle();
      chk("dual_ack", 64'(ack), 64'b0011);
      req = 4'b0000;
`else
      chk("dual_load1", 64'(ram_load1), 64'd0);
      chk("dual_addr1", 64'(ram_address1), 64'd0);
      push_rd(1, 16'h2222);
      push_rd(0, 16'h1111);
      cycle();
      chk("dual_ack1", 64'(ack), 64'b0010);
      req = 4'b0001;
      #1;
      chk("dual_addr0_b", 64'(ram_address0), 64'h0001);
      cycle();
      chk("dual_ack0", 64'(ack), 64'b0001);
      req = 4'b0000;
`endif
      cycle();

      // Park ptr at 0, then write and read of the same address together.
      apply_vec('{3, 1'b1, 16'h0006, 16'h0606, 16'h0000});
      req = 4'b0011; we = 4'b0001;
      addr[0*AW +: AW]  = 16'h0005;
      addr[1*AW +: AW]  = 16'h0005;
      wdata[0*BW +: BW] = 16'h5555;
      #1;
      chk("haz_save", 64'(ram_save), 64'd1);
      chk("haz_addr0", 64'(ram_address0), 64'h0005);
      chk("haz_load1", 64'(ram_load1), 64'd0);
      push_wr(0);
      push_rd(1, 16'h5555);
      cycle();
      chk("haz_ack0", 64'(ack), 64'b0001);
      req = 4'b0010; we = 4'b0000;
      #1;
      chk("haz_load0", 64'(ram_load0), 64'd1);
      chk("haz_addr0_b", 64'(ram_address0), 64'h0005);
      cycle();
      chk("haz_ack1", 64'(ack), 64'b0010);
      req = 4'b0000;
      cycle();
      cycle();

      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule
